// File: rtl/serial_frame_rx_ctrl_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_rx_ctrl_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/serial_frame_rx_ctrl_if.sv
// Serial line, bit strobe and byte handshake bundle for the frame receiver.
interface serial_frame_rx_ctrl_if;
  import serial_frame_rx_ctrl_pkg::*;

  logic                 en;
  logic                 si;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 busy;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  // Driver of the serial line and consumer of bytes.
  modport master (
    output en, si, rx_ready,
    input  rx_data, rx_valid, busy, bit_cnt, frame_err, parity_err, overrun
  );

  // The receiver itself.
  modport slave (
    input  en, si, rx_ready,
    output rx_data, rx_valid, busy, bit_cnt, frame_err, parity_err, overrun
  );

endinterface

// File: rtl/serial_frame_rx_ctrl_sipo_shift_counter.sv
// Serial-in shift register (LSB first) with a data-bit counter.
// The counter wraps 7 -> 0 on its own; carry flags the last data bit.
module sipo_shift_counter
  import serial_frame_rx_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic                 si,
  output logic [DATA_BITS-1:0] shift,
  output logic [CNT_W-1:0]     cnt,
  output logic                 carry
);

  // Shift new bit into the MSB and count it; clear only resets the counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      cnt   <= '0;
    end else if (clr) begin
      cnt   <= '0;
    end else if (shift_en) begin
      shift <= {si, shift[DATA_BITS-1:1]};
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign carry = (cnt == CNT_W'(DATA_BITS - 1));

endmodule

// File: rtl/serial_frame_rx_ctrl.sv
// Frame sequencer: start detect, eight data bits, optional parity, stop check,
// one-entry holding buffer with valid/ready, and single-cycle error pulses.
module serial_frame_rx_ctrl
  import serial_frame_rx_ctrl_pkg::*;
#(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  serial_frame_rx_ctrl_if.slave bus
);

  rx_state_e            state_q, state_d;
  logic                 clr, shift_en, carry;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     cnt;
  logic                 par_bad_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q, parity_err_q, overrun_q;

  logic stop_sample, frame_bad, parity_fail, good, drain, load, overrun_hit;

  sipo_shift_counter u_sipo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .si       (bus.si),
    .shift    (shift),
    .cnt      (cnt),
    .carry    (carry)
  );

  // Next-state and datapath strobes; everything advances only on en.
  // NOTE: every output of this block gets a default first so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && !bus.si) begin
          clr     = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.en) begin
          shift_en = 1'b1;
          if (carry) state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY:  if (bus.en) state_d = STOP;
      STOP:    if (bus.en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Parity mismatch latch: cleared at start, captured on the parity bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              par_bad_q <= 1'b0;
    else if (clr)                         par_bad_q <= 1'b0;
    else if (bus.en && state_q == PARITY) par_bad_q <= ((^shift) ^ bus.si) != PARITY_ODD;
  end

  // Stop-bit outcome, prioritised frame error > parity error > overrun.
  assign stop_sample = bus.en && (state_q == STOP);
  assign frame_bad   = stop_sample && !bus.si;
  assign parity_fail = stop_sample && bus.si && par_bad_q;
  assign good        = stop_sample && bus.si && !par_bad_q;
  assign drain       = rx_valid_q && bus.rx_ready;
  assign load        = good && (!rx_valid_q || drain);
  assign overrun_hit = good && rx_valid_q && !drain;

  // Holding buffer: a same-edge load wins over a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (load) begin
      rx_data_q  <= shift;
      rx_valid_q <= 1'b1;
    end else if (drain) begin
      rx_valid_q <= 1'b0;
    end
  end

  // One-cycle error pulses, visible the cycle after the stop edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= frame_bad;
      parity_err_q <= parity_fail;
      overrun_q    <= overrun_hit;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.bit_cnt    = cnt;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx_ctrl.sv
// Bench for serial_frame_rx_ctrl: unit 0 without parity, unit 1 with even
// parity. A frame-level model predicts every output each cycle; directed
// frames add literal expectations.
module tb_serial_frame_rx_ctrl;

  localparam bit [1:0] PEN  = 2'b10;
  localparam bit [1:0] PODD = 2'b00;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_frame_rx_ctrl_if ifc0 ();
  serial_frame_rx_ctrl_if ifc1 ();

  serial_frame_rx_ctrl #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
    .clk (clk), .rst (rst), .bus (ifc0.slave));
  serial_frame_rx_ctrl #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk (clk), .rst (rst), .bus (ifc1.slave));

  // Reference model: pos = bits collected after the start bit, -1 when idle.
  int         m_pos   [2];
  logic [9:0] m_bits  [2];
  logic [7:0] m_data  [2];
  bit         m_valid [2];
  bit         m_fe    [2];
  bit         m_pe    [2];
  bit         m_ov    [2];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset(int k);
    m_pos[k]   = -1;
    m_bits[k]  = '0;
    m_data[k]  = '0;
    m_valid[k] = 1'b0;
    m_fe[k]    = 1'b0;
    m_pe[k]    = 1'b0;
    m_ov[k]    = 1'b0;
  endfunction

  function automatic void model_step(int k, bit e, bit d, bit r);
    int         flen;
    bit         drain, load, par_ok;
    logic [7:0] byte_v;
    flen   = PEN[k] ? 10 : 9;
    drain  = m_valid[k] && r;
    load   = 1'b0;
    byte_v = m_bits[k][7:0];
    m_fe[k] = 1'b0;
    m_pe[k] = 1'b0;
    m_ov[k] = 1'b0;
    if (e) begin
      if (m_pos[k] < 0) begin
        if (!d) m_pos[k] = 0;
      end else begin
        m_bits[k][m_pos[k]] = d;
        m_pos[k]++;
        if (m_pos[k] == flen) begin
          byte_v = m_bits[k][7:0];
          par_ok = !PEN[k] ||
                   ((($countones(byte_v) + int'(m_bits[k][8])) % 2) == int'(PODD[k]));
          if (!m_bits[k][flen-1])           m_fe[k] = 1'b1;
          else if (!par_ok)                 m_pe[k] = 1'b1;
          else if (m_valid[k] && !drain)    m_ov[k] = 1'b1;
          else                              load = 1'b1;
          m_pos[k] = -1;
        end
      end
    end
    if (load) begin
      m_data[k]  = byte_v;
      m_valid[k] = 1'b1;
    end else if (drain) begin
      m_valid[k] = 1'b0;
    end
  endfunction

  function automatic logic [2:0] exp_cnt(int k);
    return (m_pos[k] >= 0 && m_pos[k] < 8) ? 3'(m_pos[k]) : 3'd0;
  endfunction

  // Model advances on the same edges as the DUTs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, ifc0.en, ifc0.si, ifc0.rx_ready);
      model_step(1, ifc1.en, ifc1.si, ifc1.rx_ready);
    end
  end

  task automatic cmp(input int k, input logic [7:0] d, input logic v, input logic b,
                     input logic [2:0] c, input logic fe, input logic pe, input logic ov);
    check($sformatf("u%0d_rx_data", k),    16'(d),  16'(m_data[k]));
    check($sformatf("u%0d_rx_valid", k),   16'(v),  16'(m_valid[k]));
    check($sformatf("u%0d_busy", k),       16'(b),  16'(m_pos[k] >= 0));
    check($sformatf("u%0d_bit_cnt", k),    16'(c),  16'(exp_cnt(k)));
    check($sformatf("u%0d_frame_err", k),  16'(fe), 16'(m_fe[k]));
    check($sformatf("u%0d_parity_err", k), 16'(pe), 16'(m_pe[k]));
    check($sformatf("u%0d_overrun", k),    16'(ov), 16'(m_ov[k]));
  endtask

  // Compare process on the inactive edge.
  always @(negedge clk) begin
    cmp(0, ifc0.rx_data, ifc0.rx_valid, ifc0.busy, ifc0.bit_cnt,
        ifc0.frame_err, ifc0.parity_err, ifc0.overrun);
    cmp(1, ifc1.rx_data, ifc1.rx_valid, ifc1.busy, ifc1.bit_cnt,
        ifc1.frame_err, ifc1.parity_err, ifc1.overrun);
  end

  // One cycle of stimulus on unit s; the other unit idles with en low.
  task automatic cyc(input bit s, input bit e, input bit d, input bit r);
    @(negedge clk);
    ifc0.en       = s ? 1'b0 : e;
    ifc0.si       = s ? 1'b1 : d;
    ifc0.rx_ready = s ? 1'b0 : r;
    ifc1.en       = s ? e : 1'b0;
    ifc1.si       = s ? d : 1'b1;
    ifc1.rx_ready = s ? r : 1'b0;
  endtask

  function automatic logic [2:0] cnt_of(input bit s);
    return s ? ifc1.bit_cnt : ifc0.bit_cnt;
  endfunction

  function automatic logic busy_of(input bit s);
    return s ? ifc1.busy : ifc0.busy;
  endfunction

  // Directed frame; gap_at >= 0 stalls en for 5 cycles before that data bit.
  task automatic send_frame(input bit s, input logic [7:0] d, input bit par,
                            input bit stop, input bit rdy_stop, input int gap_at);
    cyc(s, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        repeat (5) begin
          cyc(s, 1'b0, 1'b0, 1'b0);
          check("gate_bit_cnt", 16'(cnt_of(s)), 16'(i));
          check("gate_busy", 16'(busy_of(s)), 16'd1);
        end
      end
      cyc(s, 1'b1, d[i], 1'b0);
    end
    if (PEN[s]) cyc(s, 1'b1, par, 1'b0);
    cyc(s, 1'b1, stop, rdy_stop);
  endtask

  // Random frame with random en stalls, consumer readiness and faults.
  task automatic rand_frame(input bit s);
    logic [7:0] d;
    bit         p, stop;
    bit         b[$];
    d    = 8'($urandom);
    p    = (^d) ^ PODD[s];
    if ($urandom_range(0, 7) == 0) p = ~p;
    stop = ($urandom_range(0, 7) != 0);
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (PEN[s]) b.push_back(p);
    b.push_back(stop);
    foreach (b[i]) begin
      while ($urandom_range(0, 3) == 0) cyc(s, 1'b0, 1'($urandom), 1'($urandom));
      cyc(s, 1'b1, b[i], 1'($urandom));
    end
    repeat ($urandom_range(0, 3)) cyc(s, 1'($urandom), 1'b1, 1'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    ifc0.en = 1'b0; ifc0.si = 1'b1; ifc0.rx_ready = 1'b0;
    ifc1.en = 1'b0; ifc1.si = 1'b1; ifc1.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data", 16'(ifc0.rx_data), 16'h00);
    check("rst_rx_valid", 16'(ifc0.rx_valid), 16'd0);
    check("rst_busy", 16'(ifc1.busy), 16'd0);
    check("rst_bit_cnt", 16'(ifc1.bit_cnt), 16'd0);
    rst = 1'b0;

    // Good byte, no parity.
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, -1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("good_valid", 16'(ifc0.rx_valid), 16'd1);
    check("good_data", 16'(ifc0.rx_data), 16'hA5);
    check("good_busy", 16'(ifc0.busy), 16'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("drain_valid", 16'(ifc0.rx_valid), 16'd0);

    // Even parity: 0x03 with parity 0 good, 0x07 with parity 0 bad.
    send_frame(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, -1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("par_ok_valid", 16'(ifc1.rx_valid), 16'd1);
    check("par_ok_data", 16'(ifc1.rx_data), 16'h03);
    send_frame(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, -1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("par_err_pulse", 16'(ifc1.parity_err), 16'd1);
    check("par_err_data", 16'(ifc1.rx_data), 16'h03);
    check("par_err_ovr", 16'(ifc1.overrun), 16'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("par_err_single", 16'(ifc1.parity_err), 16'd0);

    // Framing error then recovery.
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, -1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("fe_pulse", 16'(ifc0.frame_err), 16'd1);
    check("fe_no_load", 16'(ifc0.rx_valid), 16'd0);
    check("fe_idle", 16'(ifc0.busy), 16'd0);
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b0, -1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("fe_next_data", 16'(ifc0.rx_data), 16'h11);
    check("fe_next_valid", 16'(ifc0.rx_valid), 16'd1);

    // Overrun, then drain-and-load on the second stop edge.
    send_frame(1'b0, 8'h12, 1'b0, 1'b1, 1'b0, -1);
    send_frame(1'b0, 8'h34, 1'b0, 1'b1, 1'b0, -1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("ovr_data", 16'(ifc0.rx_data), 16'h12);
    check("ovr_pulse", 16'(ifc0.overrun), 16'd1);
    send_frame(1'b0, 8'h12, 1'b0, 1'b1, 1'b0, -1);
    send_frame(1'b0, 8'h34, 1'b0, 1'b1, 1'b1, -1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("drainload_data", 16'(ifc0.rx_data), 16'h34);
    check("drainload_valid", 16'(ifc0.rx_valid), 16'd1);
    check("drainload_ovr", 16'(ifc0.overrun), 16'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);

    // Enable gating at bit_cnt=3.
    send_frame(1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("gate_data", 16'(ifc0.rx_data), 16'hC3);

    // Reset at bit_cnt=5 with a full buffer.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'(i & 1), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_rst_cnt", 16'(ifc0.bit_cnt), 16'd5);
    check("pre_rst_valid", 16'(ifc0.rx_valid), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", 16'(ifc0.rx_valid), 16'd0);
    check("rst_async_busy", 16'(ifc0.busy), 16'd0);
    check("rst_async_cnt", 16'(ifc0.bit_cnt), 16'd0);
    check("rst_async_data", 16'(ifc0.rx_data), 16'h00);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (12) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("post_rst_valid", 16'(ifc0.rx_valid), 16'd0);

    // Randomised frames on both units.
    for (int s = 0; s < 2; s++) repeat (150) rand_frame(1'(s));
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
